// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential issue front end for the external 32-bit ALU.
// Accepts RV32I OP / OP-IMM instructions over a valid/ready handshake,
// reads operands from an internal 32x32 register file, drives registered
// operands and a 4-bit opcode to the ALU, waits EXEC_WAIT cycles, then
// writes the ALU result back to rd and pulses done.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   instr_valid/ready     instruction handshake
//   instr[31:0]           RV32I instruction word
//   alu_in0/alu_in1[31:0] registered ALU operands
//   alu_op[3:0]           registered ALU opcode (0000 = no operation)
//   alu_out[31:0]         ALU result
//   done, done_rd, done_data  one-cycle writeback report
//   illegal               one-cycle pulse for a rejected instruction
//   dbg_addr/dbg_data     combinational register-file debug read
module alu_issue_ctrl #(
  parameter int unsigned EXEC_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [31:0] alu_in0,
  output logic [31:0] alu_in1,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out,
  output logic        done,
  output logic [4:0]  done_rd,
  output logic [31:0] done_data,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_AND  = 4'b0001,
    OP_OR   = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_ADD  = 4'b0100,
    OP_SUB  = 4'b0101,
    OP_SRA  = 4'b0111,
    OP_SLL  = 4'b1000,
    OP_SRL  = 4'b1001,
    OP_SLT  = 4'b1100,
    OP_SLTU = 4'b1101
  } alu_op_e;

  state_t      state_q;
  logic [31:0] instr_q;
  logic [31:0] regs_q [32];
  logic [3:0]  cnt_q;
  logic [31:0] alu_in0_q;
  logic [31:0] alu_in1_q;
  alu_op_e     alu_op_q;
  logic        done_q;
  logic        illegal_q;
  logic [4:0]  done_rd_q;
  logic [31:0] done_data_q;

  // Decode of the latched instruction
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [31:0] opb;
  logic [4:0]  shamt;
  logic        is_op;
  logic        is_imm;
  logic        dec_legal_d;
  alu_op_e     dec_op_d;
  logic [31:0] dec_in0_d;
  logic [31:0] dec_in1_d;

  always_comb begin
    opcode  = instr_q[6:0];
    rd      = instr_q[11:7];
    funct3  = instr_q[14:12];
    funct7  = instr_q[31:25];
    rs1_val = regs_q[instr_q[19:15]];
    rs2_val = regs_q[instr_q[24:20]];
    imm     = {{20{instr_q[31]}}, instr_q[31:20]};
    is_op   = (opcode == 7'b0110011);
    is_imm  = (opcode == 7'b0010011);
    opb     = is_op ? rs2_val : imm;
    shamt   = is_op ? rs2_val[4:0] : instr_q[24:20];

    dec_legal_d = 1'b0;
    if (is_op) begin
      dec_legal_d = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) &&
                     ((funct3 == 3'b000) || (funct3 == 3'b101)));
    end else if (is_imm) begin
      case (funct3)
        3'b001:  dec_legal_d = (funct7 == 7'b0000000);
        3'b101:  dec_legal_d = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        default: dec_legal_d = 1'b1;
      endcase
    end

    dec_op_d  = OP_NOP;
    dec_in0_d = rs1_val;
    dec_in1_d = opb;
    case (funct3)
      3'b000: dec_op_d = (is_op && funct7[5]) ? OP_SUB : OP_ADD;
      3'b001: begin
        dec_op_d  = OP_SLL;
        dec_in1_d = {27'b0, shamt};
      end
      // ALU computes in0 > in1, so set-less-than swaps the operands
      3'b010: begin
        dec_op_d  = OP_SLT;
        dec_in0_d = opb;
        dec_in1_d = rs1_val;
      end
      3'b011: begin
        dec_op_d  = OP_SLTU;
        dec_in0_d = opb;
        dec_in1_d = rs1_val;
      end
      3'b100: dec_op_d = OP_XOR;
      3'b101: begin
        dec_op_d  = funct7[5] ? OP_SRA : OP_SRL;
        dec_in1_d = {27'b0, shamt};
      end
      3'b110: dec_op_d = OP_OR;
      default: dec_op_d = OP_AND;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      cnt_q       <= '0;
      alu_in0_q   <= '0;
      alu_in1_q   <= '0;
      alu_op_q    <= OP_NOP;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      done_rd_q   <= '0;
      done_data_q <= '0;
      for (int unsigned i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_legal_d) begin
            alu_in0_q <= dec_in0_d;
            alu_in1_q <= dec_in1_d;
            alu_op_q  <= dec_op_d;
            cnt_q     <= 4'(EXEC_WAIT);
            state_q   <= S_EXEC;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_EXEC: begin
          if (cnt_q <= 4'd1) begin
            if (rd != 5'd0) begin
              regs_q[rd] <= alu_out;
            end
            done_q      <= 1'b1;
            done_rd_q   <= rd;
            done_data_q <= alu_out;
            alu_op_q    <= OP_NOP;
            cnt_q       <= '0;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign alu_in0     = alu_in0_q;
  assign alu_in1     = alu_in1_q;
  assign alu_op      = alu_op_q;
  assign done        = done_q;
  assign done_rd     = done_rd_q;
  assign done_data   = done_data_q;
  assign illegal     = illegal_q;
  assign dbg_data    = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

endmodule
